// File: rtl/reg_file_ctrl_if.sv
// Bus bundle between the command controller, the UART RX/TX byte paths and
// the 8x16 register file. Signal names follow the surrounding design.
//
// Handshake rules:
//   RX path  : a byte is taken on any rising CLK edge where RX_D_VLD=1. There
//              is no backpressure; a byte arriving in a busy state is lost.
//   TX path  : TX_D_VLD is the request. It stays high with TX_P_DATA frozen
//              until TX_BUSY is seen high (acceptance). The next byte is not
//              offered until TX_BUSY has been seen low again.
//   Reg file : WrEn writes WrData to Address on the same edge. RdEn is a
//              one-cycle request; RdData is valid from the following edge.
interface reg_file_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int BYTE_WIDTH = 8
);
   logic [BYTE_WIDTH-1:0] RX_P_DATA;
   logic                  RX_D_VLD;
   logic [DATA_WIDTH-1:0] RdData;
   logic                  WrEn;
   logic                  RdEn;
   logic [ADDR_WIDTH-1:0] Address;
   logic [DATA_WIDTH-1:0] WrData;
   logic [BYTE_WIDTH-1:0] TX_P_DATA;
   logic                  TX_D_VLD;
   logic                  TX_BUSY;
   logic                  CMD_ERR;
   // Current controller state, for checkers and debug visibility.
   logic [3:0]            dbgState;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, TX_BUSY,
      output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR,
             dbgState
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, TX_BUSY,
      input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR,
             dbgState
   );
endinterface

// File: rtl/reg_file_ctrl.sv
// Command-side master for the register file. Parses UART byte frames
//   write : WR_CMD, addr, data_lo, data_hi
//   read  : RD_CMD, addr  -> returns data_lo, data_hi on the TX path
// and issues one-cycle register-file write/read strobes. All outputs are
// registered; state is exported on bus.dbgState.
module reg_file_ctrl #(
   parameter int                   DATA_WIDTH = 16,
   parameter int                   ADDR_WIDTH = 3,
   parameter int                   BYTE_WIDTH = 8,
   parameter logic [BYTE_WIDTH-1:0] WR_CMD    = 8'hAA,
   parameter logic [BYTE_WIDTH-1:0] RD_CMD    = 8'hBB
) (
   input logic              CLK,
   input logic              RST,
   reg_file_ctrl_if.master  bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      WR_ADDR = 4'd1,
      WR_LO   = 4'd2,
      WR_HI   = 4'd3,
      WR_EXEC = 4'd4,
      RD_ADDR = 4'd5,
      RD_EXEC = 4'd6,
      RD_WAIT = 4'd7,
      TX_LO   = 4'd8,
      TX_HI   = 4'd9
   } ctrlState_t;

   ctrlState_t            state;
   logic                  wrEnReg;
   logic                  rdEnReg;
   logic [ADDR_WIDTH-1:0] addrReg;
   logic [DATA_WIDTH-1:0] wrDataReg;
   logic [DATA_WIDTH-1:0] rdBuf;
   logic [BYTE_WIDTH-1:0] txDataReg;
   logic                  txVldReg;
   logic                  cmdErrReg;

   logic                  rxVld;
   logic [BYTE_WIDTH-1:0] rxByte;
   logic                  txBusy;

   assign rxVld  = bus.RX_D_VLD;
   assign rxByte = bus.RX_P_DATA;
   assign txBusy = bus.TX_BUSY;

   // Frame parser, register-file strobes and two-byte TX handshake.
   // In TX_LO/TX_HI the TX_D_VLD register doubles as the handshake phase:
   // high = waiting for TX_BUSY=1 (acceptance), low = waiting for TX_BUSY=0.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         wrEnReg   <= 1'b0;
         rdEnReg   <= 1'b0;
         addrReg   <= '0;
         wrDataReg <= '0;
         rdBuf     <= '0;
         txDataReg <= '0;
         txVldReg  <= 1'b0;
         cmdErrReg <= 1'b0;
      end else begin
         // CMD_ERR is a single-cycle pulse unless re-armed below.
         cmdErrReg <= 1'b0;
         case (state)
            IDLE: begin
               if (rxVld) begin
                  if (rxByte == WR_CMD) begin
                     state <= WR_ADDR;
                  end else if (rxByte == RD_CMD) begin
                     state <= RD_ADDR;
                  end else begin
                     cmdErrReg <= 1'b1;
                  end
               end
            end

            WR_ADDR: begin
               if (rxVld) begin
                  // Upper address bits of the byte are ignored.
                  addrReg <= rxByte[ADDR_WIDTH-1:0];
                  state   <= WR_LO;
               end
            end

            WR_LO: begin
               // Payload bytes are data even if they match a command code.
               if (rxVld) begin
                  wrDataReg[BYTE_WIDTH-1:0] <= rxByte;
                  state                     <= WR_HI;
               end
            end

            WR_HI: begin
               if (rxVld) begin
                  wrDataReg[DATA_WIDTH-1:BYTE_WIDTH] <= rxByte;
                  wrEnReg                            <= 1'b1;
                  state                              <= WR_EXEC;
               end
            end

            WR_EXEC: begin
               // WrEn was high for exactly this cycle; RX bytes are dropped.
               wrEnReg <= 1'b0;
               state   <= IDLE;
            end

            RD_ADDR: begin
               if (rxVld) begin
                  addrReg <= rxByte[ADDR_WIDTH-1:0];
                  rdEnReg <= 1'b1;
                  state   <= RD_EXEC;
               end
            end

            RD_EXEC: begin
               rdEnReg <= 1'b0;
               state   <= RD_WAIT;
            end

            RD_WAIT: begin
               // Register file drives RdData one edge after RdEn. The low byte
               // is loaded straight into the TX register so it is presented
               // together with TX_D_VLD on entry to TX_LO.
               rdBuf     <= bus.RdData;
               txDataReg <= bus.RdData[BYTE_WIDTH-1:0];
               txVldReg  <= 1'b1;
               state     <= TX_LO;
            end

            TX_LO: begin
               if (txVldReg) begin
                  // Hold the low byte while the request is outstanding.
                  txDataReg <= rdBuf[BYTE_WIDTH-1:0];
                  if (txBusy) begin
                     txVldReg <= 1'b0;
                  end
               end else if (!txBusy) begin
                  txDataReg <= rdBuf[DATA_WIDTH-1:BYTE_WIDTH];
                  txVldReg  <= 1'b1;
                  state     <= TX_HI;
               end
            end

            TX_HI: begin
               if (txVldReg) begin
                  if (txBusy) begin
                     txVldReg <= 1'b0;
                  end
               end else if (!txBusy) begin
                  state <= IDLE;
               end
            end

            default: begin
               wrEnReg  <= 1'b0;
               rdEnReg  <= 1'b0;
               txVldReg <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.WrEn      = wrEnReg;
   assign bus.RdEn      = rdEnReg;
   assign bus.Address   = addrReg;
   assign bus.WrData    = wrDataReg;
   assign bus.TX_P_DATA = txDataReg;
   assign bus.TX_D_VLD  = txVldReg;
   assign bus.CMD_ERR   = cmdErrReg;
   assign bus.dbgState  = state;

   // Write and read strobes are mutually exclusive.
   aStrobeExcl : assert property (@(posedge CLK) disable iff (!RST)
      !(bus.WrEn && bus.RdEn));

   // Each strobe lasts a single cycle.
   aWrEnPulse : assert property (@(posedge CLK) disable iff (!RST)
      bus.WrEn |=> !bus.WrEn);
   aRdEnPulse : assert property (@(posedge CLK) disable iff (!RST)
      bus.RdEn |=> !bus.RdEn);

   // The offered TX byte does not move while the request is held.
   aTxStable : assert property (@(posedge CLK) disable iff (!RST)
      (bus.TX_D_VLD && $past(bus.TX_D_VLD)) |-> $stable(bus.TX_P_DATA));

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl: drives UART-style byte frames, models the
// register file and the transmitter handshake, and checks strobes, addresses,
// data and returned bytes against hand-computed constants.
module tb_reg_file_ctrl;

   logic CLK;
   logic RST;

   reg_file_ctrl_if bus ();

   reg_file_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks    = 0;
   int failures  = 0;
   int wrCycles  = 0;
   int rdCycles  = 0;
   int errCycles = 0;
   int bothHigh  = 0;
   int txChange  = 0;

   logic [2:0]  lastWrAddr = '0;
   logic [2:0]  lastRdAddr = '0;
   logic [15:0] lastWrData = '0;
   logic        prevVld    = 1'b0;
   logic [7:0]  prevTx     = '0;
   logic [15:0] regMem [8];

   // Clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Register-file model and bus monitor, sampled mid-cycle.
   always @(negedge CLK) begin
      if (RST) begin
         if (bus.WrEn) begin
            wrCycles++;
            lastWrAddr = bus.Address;
            lastWrData = bus.WrData;
            regMem[bus.Address] = bus.WrData;
         end
         if (bus.RdEn) begin
            rdCycles++;
            lastRdAddr = bus.Address;
            bus.RdData = regMem[bus.Address];
         end
         if (bus.CMD_ERR) errCycles++;
         if (bus.WrEn && bus.RdEn) bothHigh++;
         if (bus.TX_D_VLD && prevVld && (bus.TX_P_DATA !== prevTx)) txChange++;
      end
      prevVld = bus.TX_D_VLD;
      prevTx  = bus.TX_P_DATA;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge CLK);
   endtask

   task automatic sendByte(input logic [7:0] b);
      @(negedge CLK);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(negedge CLK);
      bus.RX_D_VLD  = 1'b0;
   endtask

   task automatic waitVld(input string tag);
      int n;
      n = 0;
      while (bus.TX_D_VLD !== 1'b1 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      check({tag, "_vld_seen"}, {31'd0, bus.TX_D_VLD}, 32'd1);
   endtask

   // Receive one TX byte: check it, leave the request pending `delay` cycles,
   // then raise TX_BUSY for `hold` cycles (hold >= 1).
   task automatic recvTx(input string tag, input logic [7:0] exp, input int delay, input int hold);
      waitVld(tag);
      if (bus.TX_D_VLD !== 1'b1) return;
      check({tag, "_data"}, {24'd0, bus.TX_P_DATA}, {24'd0, exp});
      repeat (delay) @(negedge CLK);
      check({tag, "_vld_held"}, {31'd0, bus.TX_D_VLD}, 32'd1);
      check({tag, "_data_held"}, {24'd0, bus.TX_P_DATA}, {24'd0, exp});
      bus.TX_BUSY = 1'b1;
      @(negedge CLK);
      check({tag, "_vld_drop"}, {31'd0, bus.TX_D_VLD}, 32'd0);
      repeat (hold - 1) @(negedge CLK);
      bus.TX_BUSY = 1'b0;
   endtask

   task automatic doWrite(input string tag, input logic [7:0] a, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [2:0] expAddr,
                          input logic [15:0] expData);
      int wrBase;
      int errBase;
      wrBase  = wrCycles;
      errBase = errCycles;
      sendByte(8'hAA);
      sendByte(a);
      sendByte(lo);
      sendByte(hi);
      waitCycles(3);
      check({tag, "_wren_cycles"}, wrCycles - wrBase, 32'd1);
      check({tag, "_addr"}, {29'd0, lastWrAddr}, {29'd0, expAddr});
      check({tag, "_wdata"}, {16'd0, lastWrData}, {16'd0, expData});
      check({tag, "_no_err"}, errCycles - errBase, 32'd0);
   endtask

   task automatic doRead(input string tag, input logic [7:0] a, input logic [2:0] expAddr,
                         input logic [7:0] expLo, input logic [7:0] expHi);
      int rdBase;
      rdBase = rdCycles;
      sendByte(8'hBB);
      sendByte(a);
      recvTx({tag, "_lo"}, expLo, 2, 3);
      recvTx({tag, "_hi"}, expHi, 1, 2);
      waitCycles(2);
      check({tag, "_rden_cycles"}, rdCycles - rdBase, 32'd1);
      check({tag, "_raddr"}, {29'd0, lastRdAddr}, {29'd0, expAddr});
      check({tag, "_idle"}, {28'd0, bus.dbgState}, 32'd0);
   endtask

   initial begin
      int wrBase;
      int rdBase;
      int errBase;

      for (int i = 0; i < 8; i++) regMem[i] = '0;
      bus.RX_P_DATA = '0;
      bus.RX_D_VLD  = 1'b0;
      bus.TX_BUSY   = 1'b0;
      bus.RdData    = '0;
      RST = 1'b1;
      #2 RST = 1'b0;
      #1;

      // Reset state
      check("rst_wren",  {31'd0, bus.WrEn},     32'd0);
      check("rst_rden",  {31'd0, bus.RdEn},     32'd0);
      check("rst_txvld", {31'd0, bus.TX_D_VLD}, 32'd0);
      check("rst_cmderr",{31'd0, bus.CMD_ERR},  32'd0);
      check("rst_addr",  {29'd0, bus.Address},  32'd0);
      check("rst_wdata", {16'd0, bus.WrData},   32'd0);
      check("rst_txdata",{24'd0, bus.TX_P_DATA},32'd0);
      check("rst_state", {28'd0, bus.dbgState}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      // Write then read
      doWrite("t1_wr", 8'h03, 8'h23, 8'h00, 3'd3, 16'd35);
      doRead ("t1_rd", 8'h03, 3'd3, 8'h23, 8'h00);

      // Two writes back-to-back, read back in reverse order
      doWrite("t2_wr1", 8'h01, 8'h66, 8'h00, 3'd1, 16'd102);
      doWrite("t2_wr7", 8'h07, 8'h8F, 8'h00, 3'd7, 16'd143);
      doRead ("t2_rd7", 8'h07, 3'd7, 8'h8F, 8'h00);
      doRead ("t2_rd1", 8'h01, 3'd1, 8'h66, 8'h00);

      // Bad command byte
      errBase = errCycles;
      wrBase  = wrCycles;
      rdBase  = rdCycles;
      sendByte(8'h55);
      waitCycles(3);
      check("t3_cmderr_cycles", errCycles - errBase, 32'd1);
      check("t3_no_wr", wrCycles - wrBase, 32'd0);
      check("t3_no_rd", rdCycles - rdBase, 32'd0);
      check("t3_idle", {28'd0, bus.dbgState}, 32'd0);
      doWrite("t3_wr", 8'h02, 8'h1B, 8'h00, 3'd2, 16'd27);

      // Bytes arriving while the transmitter is busy are dropped
      errBase = errCycles;
      wrBase  = wrCycles;
      sendByte(8'hBB);
      sendByte(8'h02);
      waitVld("t4_lo");
      check("t4_lo_data", {24'd0, bus.TX_P_DATA}, 32'h1B);
      bus.TX_BUSY = 1'b1;
      sendByte(8'hAA);
      sendByte(8'h04);
      sendByte(8'hFF);
      sendByte(8'hFF);
      repeat (12) @(negedge CLK);
      check("t4_vld_low_busy", {31'd0, bus.TX_D_VLD}, 32'd0);
      check("t4_state_txlo", {28'd0, bus.dbgState}, 32'd8);
      bus.TX_BUSY = 1'b0;
      recvTx("t4_hi", 8'h00, 0, 2);
      waitCycles(2);
      check("t4_no_wr", wrCycles - wrBase, 32'd0);
      check("t4_no_err", errCycles - errBase, 32'd0);
      doRead("t4_rd4", 8'h04, 3'd4, 8'h00, 8'h00);

      // Reset in the middle of a write frame
      wrBase = wrCycles;
      sendByte(8'hAA);
      sendByte(8'h05);
      sendByte(8'h11);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("t5_wren",  {31'd0, bus.WrEn},     32'd0);
      check("t5_rden",  {31'd0, bus.RdEn},     32'd0);
      check("t5_txvld", {31'd0, bus.TX_D_VLD}, 32'd0);
      check("t5_cmderr",{31'd0, bus.CMD_ERR},  32'd0);
      check("t5_addr",  {29'd0, bus.Address},  32'd0);
      check("t5_wdata", {16'd0, bus.WrData},   32'd0);
      check("t5_txdata",{24'd0, bus.TX_P_DATA},32'd0);
      check("t5_state", {28'd0, bus.dbgState}, 32'd0);
      @(negedge CLK);
      RST = 1'b1;
      errBase = errCycles;
      sendByte(8'h22);
      waitCycles(3);
      check("t5_cmderr_cycles", errCycles - errBase, 32'd1);
      check("t5_no_wr", wrCycles - wrBase, 32'd0);
      doRead("t5_rd5", 8'h05, 3'd5, 8'h00, 8'h00);

      // Address truncation and command codes as payload
      doWrite("t6_wr", 8'hF9, 8'hAA, 8'hBB, 3'd1, 16'hBBAA);
      doRead ("t6_rd", 8'h01, 3'd1, 8'hAA, 8'hBB);

      // TX_BUSY already high when the low byte is offered
      bus.TX_BUSY = 1'b1;
      sendByte(8'hBB);
      sendByte(8'h07);
      waitVld("t7_lo");
      check("t7_lo_data", {24'd0, bus.TX_P_DATA}, 32'h8F);
      @(negedge CLK);
      check("t7_vld_drop", {31'd0, bus.TX_D_VLD}, 32'd0);
      repeat (2) @(negedge CLK);
      bus.TX_BUSY = 1'b0;
      recvTx("t7_hi", 8'h00, 1, 1);
      waitCycles(2);
      check("t7_idle", {28'd0, bus.dbgState}, 32'd0);

      // Whole-run invariants
      check("inv_wr_rd_excl", bothHigh, 32'd0);
      check("inv_tx_stable", txChange, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_ctrl.md
Name: reg_file_ctrl

Overview:
- Command-side master for the 8x16 register file. Parses byte frames from the UART receive path and issues register-file write and read cycles.
- Returns read data as two bytes to the UART transmit path.
- Sits in the main clock domain, between the RX data synchronizer, Register_file and the TX input.

Parameters:
- DATA_WIDTH, 16, register-file word width; must equal 2 x BYTE_WIDTH.
- ADDR_WIDTH, 3, register-file address width.
- BYTE_WIDTH, 8, width of RX/TX byte paths.
- WR_CMD, 8'hAA, write-frame command byte.
- RD_CMD, 8'hBB, read-frame command byte.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  BYTE_WIDTH  received byte, valid only when RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- RdData  in  DATA_WIDTH  register-file read data.
- WrEn  out  1  register-file write enable.
- RdEn  out  1  register-file read enable.
- Address  out  ADDR_WIDTH  register-file address.
- WrData  out  DATA_WIDTH  register-file write data.
- TX_P_DATA  out  BYTE_WIDTH  byte to transmitter.
- TX_D_VLD  out  1  byte-valid request to transmitter.
- TX_BUSY  in  1  transmitter busy; a rising edge means the byte was accepted.
- CMD_ERR  out  1  one-cycle pulse on an unrecognised command byte.

Behaviour:
- All outputs are registered.
- On RST=0, asynchronously: state=IDLE; WrEn, RdEn, TX_D_VLD and CMD_ERR = 0; Address, WrData, TX_P_DATA and the internal read buffer = 0.
- Reset mid-frame aborts the frame. No partial write is ever issued.
- A byte is consumed only on a rising edge with RX_D_VLD=1.
- States: IDLE, WR_ADDR, WR_LO, WR_HI, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_LO, TX_HI.
- IDLE:
  - byte==WR_CMD -> WR_ADDR.
  - byte==RD_CMD -> RD_ADDR.
  - Any other byte -> CMD_ERR=1 for exactly one cycle; stay in IDLE.
- Write frame: WR_ADDR latches Address=byte[ADDR_WIDTH-1:0] (upper bits ignored) -> WR_LO latches WrData[7:0] -> WR_HI latches WrData[15:8] -> WR_EXEC.
- WR_EXEC: WrEn=1 for exactly one cycle, starting the cycle after the data_hi byte is sampled. Address and WrData are stable during that cycle. Then -> IDLE.
- Read frame: RD_ADDR latches Address -> RD_EXEC.
- RD_EXEC: RdEn=1 for exactly one cycle -> RD_WAIT.
- RD_WAIT: RdEn=0; RdData is captured into the read buffer at the end of this cycle (the register file presents data one edge after RdEn) -> TX_LO.
- TX_LO:
  - TX_P_DATA=buffer[7:0], TX_D_VLD=1.
  - Hold both until TX_BUSY is sampled 1, then drop TX_D_VLD.
  - Wait until TX_BUSY is sampled 0, then -> TX_HI.
- TX_HI: same handshake with buffer[15:8], then -> IDLE.
- Minimum TX_D_VLD high time is 1 cycle. TX_P_DATA must not change while TX_D_VLD=1.
- RX bytes arriving in WR_EXEC, RD_EXEC, RD_WAIT, TX_LO or TX_HI are dropped silently. CMD_ERR is not asserted for them.
- Command bytes arriving as payload, e.g. 8'hAA as data_lo, are treated as data, not re-parsed.
- WrEn and RdEn are never high in the same cycle.
- Address holds its last value outside frames. WrData holds its last value.
- TX_BUSY already high on entry to TX_LO: the controller still drives TX_D_VLD and treats the first sampled TX_BUSY=1 as acceptance.
- There is no timeout. A partially received frame waits indefinitely for further bytes.

Test Plan:
- Write then read: RX AA,03,23,00 -> WrEn pulses 1 cycle with Address=3, WrData=16'd35. Then RX BB,03 -> RdEn 1 cycle, Address=3; TX bytes 8'h23 then 8'h00, each held until a TX_BUSY rising edge.
- Two writes back-to-back: AA,01,66,00 then AA,07,8F,00 -> reg1=102, reg7=143. Read 07 -> TX 8F,00. Read 01 -> TX 66,00.
- Bad command: RX 8'h55 in IDLE -> CMD_ERR high exactly 1 cycle, no WrEn/RdEn. Following AA,02,1B,00 -> WrEn with Address=2, WrData=27.
- Bytes during transmit: issue BB,02; hold TX_BUSY=1 for 20 cycles while sending AA,04,FF,FF -> no WrEn, no CMD_ERR, reg4 unchanged. TX completes 1B,00.
- Reset mid-frame: RX AA,05,11, then pulse RST low -> all outputs 0, state IDLE. Next byte 8'h22 -> CMD_ERR pulse, no write. reg5 is unchanged on read-back.
- Address truncation and payload commands: RX AA,F9,AA,BB -> WrEn with Address=1, WrData=16'hBBAA. Read 01 -> TX AA,BB.
